uart_xcvr: RTL

Parametrised full-duplex UART transceiver that replaces the fixed 8N1 receive/transmit path behind the FPGA top.
- Configurable data width, parity mode, stop-bit count and bit period.
- RX path: 2-flop synchroniser, then a receive FSM, then a receive FIFO with valid/ready output.
- TX path: valid/ready input feeding a transmit FSM.
- Provides a last-good-byte output for board LEDs and a sticky error output for a debug LED.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_fifo.sv | 55 +++++
 rtl/uart_xcvr.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and parity helper for the UART transceiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  localparam int MAX_DATA_BITS = 9;

  // Narrower words are zero-extended by the caller; zeros do not change the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input parity_e mode);
    logic p;
    p = ^data;
    case (mode)
      PAR_EVEN: parity_bit = p;
      PAR_ODD:  parity_bit = ~p;
      default:  parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Receive FIFO: push/pop in the same cycle is legal even when full or empty.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART: synchronised RX FSM into a FIFO, valid/ready TX FSM.
//
// state  | meaning (RX and TX share names)
// IDLE   | line idle; TX accepts a word here
// START  | start bit (RX: wait to mid-bit and confirm low)
// DATA   | data bits, LSB first
// PARITY | optional parity bit
// STOP   | stop bit(s); RX leaves at mid stop bit
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 rx_i,
  output logic                 tx_o,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [DATA_BITS-1:0] last_byte_o,
  input  logic                 clr_err_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 err_o
);

  localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_IDX = 4'(DATA_BITS - 1);
  localparam logic [1:0]       PAR_SEL  = PARITY[1:0];
  localparam parity_e          PAR_MODE = parity_e'(PAR_SEL);
  localparam bit               HAS_PAR  = (PARITY != 0);

  // ---------------- RX ----------------
  logic                 rx_q1, rx_s;
  rx_state_e            rx_state, rx_nxt;
  logic [CNT_W-1:0]     rx_cnt;
  logic [3:0]           rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par;
  logic                 rx_tick;
  logic                 frame_done, par_ok, rx_good, set_frame, set_par;
  logic                 fifo_empty, fifo_overflow, rx_pop;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx_i;
      rx_s  <= rx_q1;
    end
  end

  assign rx_tick = (rx_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rx_state <= RX_IDLE;
    else          rx_state <= rx_nxt;
  end

  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      RX_IDLE:   if (!rx_s) rx_nxt = RX_START;
      RX_START:  if (rx_tick) rx_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_tick && rx_idx == LAST_IDX) rx_nxt = HAS_PAR ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_tick) rx_nxt = RX_STOP;
      RX_STOP:   if (rx_tick) rx_nxt = RX_IDLE;
      default:   rx_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    frame_done = (rx_state == RX_STOP) && rx_tick;
    par_ok     = !HAS_PAR || (rx_par == parity_bit(MAX_DATA_BITS'(rx_shift), PAR_MODE));
    rx_good    = frame_done && rx_s && par_ok;
    set_frame  = frame_done && !rx_s;
    set_par    = frame_done && !par_ok;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: rx_cnt <= CNT_HALF;
        RX_START: begin
          if (rx_tick) begin
            rx_cnt <= CNT_BIT;
            rx_idx <= '0;
          end else rx_cnt <= rx_cnt - CNT_W'(1);
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            rx_idx   <= rx_idx + 4'(1);
            rx_cnt   <= CNT_BIT;
          end else rx_cnt <= rx_cnt - CNT_W'(1);
        end
        RX_PARITY: begin
          if (rx_tick) begin
            rx_par <= rx_s;
            rx_cnt <= CNT_BIT;
          end else rx_cnt <= rx_cnt - CNT_W'(1);
        end
        RX_STOP: if (!rx_tick) rx_cnt <= rx_cnt - CNT_W'(1);
        default: rx_cnt <= CNT_HALF;
      endcase
    end
  end

  // last_byte_o tracks every good frame, even one the full FIFO drops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) last_byte_o <= '0;
    else if (rx_good) last_byte_o <= rx_shift;
  end

  assign rx_valid_o = !fifo_empty;
  assign rx_pop     = rx_valid_o && rx_ready_i;

  uart_fifo #(.DATA_W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .push      (rx_good),
    .push_data (rx_shift),
    .pop       (rx_pop),
    .head      (rx_data_o),
    .empty     (fifo_empty),
    .overflow  (fifo_overflow)
  );

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      parity_err_o <= set_par       | (parity_err_o & ~clr_err_i);
      frame_err_o  <= set_frame     | (frame_err_o  & ~clr_err_i);
      overrun_o    <= fifo_overflow | (overrun_o    & ~clr_err_i);
    end
  end

  assign err_o = parity_err_o | frame_err_o | overrun_o;

  // ---------------- TX ----------------
  tx_state_e            tx_state, tx_nxt;
  logic [CNT_W-1:0]     tx_cnt;
  logic [3:0]           tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par_bit;
  logic                 tx_tick;

  assign tx_tick = (tx_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) tx_state <= TX_IDLE;
    else          tx_state <= tx_nxt;
  end

  always_comb begin
    tx_nxt = tx_state;
    case (tx_state)
      TX_IDLE:   if (tx_valid_i) tx_nxt = TX_START;
      TX_START:  if (tx_tick) tx_nxt = TX_DATA;
      TX_DATA:   if (tx_tick && tx_idx == LAST_IDX) tx_nxt = HAS_PAR ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_tick) tx_nxt = TX_STOP;
      TX_STOP:   if (tx_tick) tx_nxt = TX_IDLE;
      default:   tx_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_ready_o = (tx_state == TX_IDLE);
  end

  // tx_o is loaded alongside each state change so the line moves with the FSM.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_o       <= 1'b1;
      tx_cnt     <= '0;
      tx_idx     <= '0;
      tx_shift   <= '0;
      tx_par_bit <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid_i) begin
            tx_shift   <= tx_data_i;
            tx_par_bit <= parity_bit(MAX_DATA_BITS'(tx_data_i), PAR_MODE);
            tx_cnt     <= CNT_BIT;
            tx_idx     <= '0;
            tx_o       <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_cnt   <= CNT_BIT;
            tx_o     <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end else tx_cnt <= tx_cnt - CNT_W'(1);
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_idx <= tx_idx + 4'(1);
            tx_cnt <= CNT_BIT;
            if (tx_idx == LAST_IDX) begin
              if (HAS_PAR) tx_o <= tx_par_bit;
              else begin
                tx_o   <= 1'b1;
                tx_cnt <= CNT_STOP;
              end
            end else begin
              tx_o     <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else tx_cnt <= tx_cnt - CNT_W'(1);
        end
        TX_PARITY: begin
          if (tx_tick) begin
            tx_cnt <= CNT_STOP;
            tx_o   <= 1'b1;
          end else tx_cnt <= tx_cnt - CNT_W'(1);
        end
        TX_STOP: if (!tx_tick) tx_cnt <= tx_cnt - CNT_W'(1);
        default: tx_o <= 1'b1;
      endcase
    end
  end

endmodule
